// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/operand/result bundle between a requester and serial_adder_ctrl.
interface serial_adder_ctrl_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             Start;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Cin;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum_out;
  logic             Cout;

  modport master (
    output Start, A_in, B_in, Cin,
    input  Ready, Busy, Done, Sum_out, Cout
  );

  modport slave (
    input  Start, A_in, B_in, Cin,
    output Ready, Busy, Done, Sum_out, Cout
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Purely combinational 1-bit full-adder cell used by the serial adder.
module FA_1_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one FA_1_bit cell, LSB first, one bit per clock,
// registered carry loop, Moore-decoded Ready/Busy/Done.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;

  FA_1_bit u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.Start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Ready = 1'b0;
    bus.Busy  = 1'b0;
    bus.Done  = 1'b0;
    unique case (state)
      IDLE:    bus.Ready = 1'b1;
      RUN:     bus.Busy  = 1'b1;
      DONE:    bus.Done  = 1'b1;
      default: ;
    endcase
  end

  assign bus.Sum_out = sum_q;
  assign bus.Cout    = cout_q;

  // cnt parks at WIDTH-1 on the final edge instead of wrapping; it is
  // reloaded on the next accept, so the visible behaviour is unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            a_sh   <= bus.A_in;
            b_sh   <= bus.B_in;
            carry  <= bus.Cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= last ? cnt : cnt + 1'b1;
          if (last) begin
            sum_q  <= {fa_sum, sum_sh[WIDTH-1:1]};
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=2).
module tb_serial_adder_ctrl;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned failures;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit add; optionally raise Start with junk operands mid-run and hold it through DONE.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit inject, input string tag);
    logic [8:0]  e;
    int unsigned k;
    int unsigned busy_n;
    e = 9'(a) + 9'(b) + 9'(c);
    check({tag, ".ready"}, 32'(bus8.Ready), 32'd1);
    bus8.Start = 1'b1;
    bus8.A_in  = a;
    bus8.B_in  = b;
    bus8.Cin   = c;
    tick();
    bus8.Start = 1'b0;
    bus8.A_in  = 8'($urandom);
    bus8.B_in  = 8'($urandom);
    bus8.Cin   = 1'($urandom);
    k = 0;
    busy_n = 0;
    while (!bus8.Done && k < 40) begin
      if (bus8.Busy) busy_n++;
      if (inject && k == 3) begin
        bus8.Start = 1'b1;
        bus8.A_in  = 8'h11;
        bus8.B_in  = 8'h22;
      end
      tick();
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'd8);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, ".result"}, {23'd0, bus8.Cout, bus8.Sum_out}, {23'd0, e});
    tick();
    check({tag, ".done_width"}, {30'd0, bus8.Done, bus8.Ready}, 32'b01);
    bus8.Start = 1'b0;
    if (inject) begin
      tick();
      check({tag, ".no_restart"}, {30'd0, bus8.Busy, bus8.Ready}, 32'b01);
      check({tag, ".held"}, {23'd0, bus8.Cout, bus8.Sum_out}, {23'd0, e});
    end
  endtask

  initial begin
    logic [8:0]  e2;
    logic [7:0]  a2;
    logic [7:0]  b2;
    logic        c2;
    logic [2:0]  e_small;
    int unsigned k;
    bit          seen;

    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus8.Start = 1'b0; bus8.A_in = '0; bus8.B_in = '0; bus8.Cin = 1'b0;
    bus2.Start = 1'b0; bus2.A_in = '0; bus2.B_in = '0; bus2.Cin = 1'b0;
    tick();
    tick();
    check("reset.flags8", {29'd0, bus8.Ready, bus8.Busy, bus8.Done}, 32'b100);
    check("reset.result8", {23'd0, bus8.Cout, bus8.Sum_out}, 32'd0);
    check("reset.flags2", {29'd0, bus2.Ready, bus2.Busy, bus2.Done}, 32'b100);
    rst = 1'b0;
    tick();

    do_add8(8'h5A, 8'h33, 1'b0, 1'b0, "basic");
    do_add8(8'hFF, 8'h01, 1'b0, 1'b0, "ripple_b");
    do_add8(8'hFF, 8'h00, 1'b1, 1'b0, "ripple_cin");
    do_add8(8'hC4, 8'h7B, 1'b1, 1'b1, "ignored_start");

    // Reset during the 4th RUN cycle after a nonzero result is held.
    do_add8(8'hF0, 8'h0F, 1'b0, 1'b0, "pre_reset");
    bus8.Start = 1'b1;
    bus8.A_in  = 8'h77;
    bus8.B_in  = 8'h66;
    tick();
    bus8.Start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst.flags", {29'd0, bus8.Ready, bus8.Busy, bus8.Done}, 32'b100);
    check("midrst.result", {23'd0, bus8.Cout, bus8.Sum_out}, 32'd0);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.Done || bus8.Busy) seen = 1'b1;
    end
    check("midrst.no_done", 32'(seen), 32'd0);
    do_add8(8'h0F, 8'h01, 1'b0, 1'b0, "post_reset");

    // Start held high: second accept lands 10 edges after E0.
    a2 = 8'($urandom);
    b2 = 8'($urandom);
    c2 = 1'($urandom);
    e2 = 9'(a2) + 9'(b2) + 9'(c2);
    bus8.Start = 1'b1;
    bus8.A_in  = 8'h80;
    bus8.B_in  = 8'h80;
    bus8.Cin   = 1'b0;
    tick();
    bus8.A_in = a2;
    bus8.B_in = b2;
    bus8.Cin  = c2;
    k = 0;
    while (!bus8.Done && k < 40) begin
      tick();
      k++;
    end
    check("b2b.latency", 32'(k), 32'd8);
    check("b2b.first", {23'd0, bus8.Cout, bus8.Sum_out}, 32'h100);
    tick();
    check("b2b.idle_e9", {30'd0, bus8.Ready, bus8.Busy}, 32'b10);
    tick();
    check("b2b.accept_e10", {30'd0, bus8.Ready, bus8.Busy}, 32'b01);
    bus8.Start = 1'b0;
    bus8.A_in  = 8'($urandom);
    bus8.B_in  = 8'($urandom);
    tick();
    tick();
    tick();
    check("b2b.hold", {23'd0, bus8.Cout, bus8.Sum_out}, 32'h100);
    k = 0;
    while (!bus8.Done && k < 40) begin
      tick();
      k++;
    end
    check("b2b.second", {23'd0, bus8.Cout, bus8.Sum_out}, {23'd0, e2});
    tick();

    for (int i = 0; i < 20; i++) begin
      do_add8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "random");
    end

    // WIDTH=2: every operand/carry combination.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          e_small = 3'(a + b + c);
          bus2.Start = 1'b1;
          bus2.A_in  = 2'(a);
          bus2.B_in  = 2'(b);
          bus2.Cin   = 1'(c);
          tick();
          bus2.Start = 1'b0;
          bus2.A_in  = 2'($urandom);
          bus2.B_in  = 2'($urandom);
          k = 0;
          while (!bus2.Done && k < 10) begin
            tick();
            k++;
          end
          check("w2.latency", 32'(k), 32'd2);
          check("w2.result", {29'd0, bus2.Cout, bus2.Sum_out}, {29'd0, e_small});
          tick();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
